req_capture_encoder: RTL and testbench

Registered request-capture and priority-encode stage placed directly upstream of the 8-to-3 encode path. It detects rising edges on 8 request lines and latches them as pending events. It presents the highest-index eligible pending request as a 3-bit index on a valid/ready handshake, and clears that pending bit on acceptance. Throughput is one index per cycle; an overflow flag reports events lost to an already-pending bit.

---
 rtl/req_capture_encoder_pkg.sv | 9 +
 rtl/req_capture_encoder_if.sv | 16 +
 rtl/req_capture_encoder_prio_enc.sv | 14 +
 rtl/req_capture_encoder.sv | 52 +++++
 tb/tb_req_capture_encoder.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/req_capture_encoder_pkg.sv
// req_enc_pkg: shared constants, FSM state type and one-hot helper
package req_enc_pkg;
  localparam int N = 8;
  localparam int IDX_W = $clog2(N);
  typedef enum logic {IDLE, PRESENT} state_e;
  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/req_capture_encoder_if.sv
// req_capture_encoder_if: request inputs and valid/ready index output bundle
// slave (DUT): in req, mask, en, out_ready, clr_ovf; out out_valid, out_idx, pending, overflow
interface req_capture_encoder_if;
  import req_enc_pkg::*;
  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic en;
  logic out_ready;
  logic clr_ovf;
  logic out_valid;
  logic [IDX_W-1:0] out_idx;
  logic [N-1:0] pending;
  logic overflow;
  modport master (output req, mask, en, out_ready, clr_ovf, input out_valid, out_idx, pending, overflow);
  modport slave (input req, mask, en, out_ready, clr_ovf, output out_valid, out_idx, pending, overflow);
endinterface

// File: rtl/req_capture_encoder_prio_enc.sv
// prio_enc: highest-set-bit encoder; in vec[N], out idx[IDX_W] and any (vec != 0)
module prio_enc
  import req_enc_pkg::*;
(
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) idx = vec[i] ? i[IDX_W-1:0] : idx;
  end
  assign any = |vec;
endmodule

// File: rtl/req_capture_encoder.sv
// req_capture_encoder: rising-edge request capture with priority-encoded valid/ready index output
// ports: clk, rst_n (async active-low), bus (req_capture_encoder_if.slave)
module req_capture_encoder
  import req_enc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  req_capture_encoder_if.slave bus
);
  state_e state_q, state_d;
  logic [N-1:0] req_q, req_d, pending_q, pending_d, rise, clr_vec, cand;
  logic [IDX_W-1:0] idx_q, idx_d, enc_idx;
  logic ovf_q, ovf_d, hs, any;
  prio_enc u_prio (.vec(cand), .idx(enc_idx), .any(any));
  // the bit being accepted this cycle is neither re-selectable nor an overflow source
  always_comb begin
    req_d = bus.req;
    rise = bus.req & ~req_q;
    hs = (state_q == PRESENT) & bus.out_ready;
    clr_vec = hs ? onehot(idx_q) : '0;
    pending_d = (pending_q & ~clr_vec) | rise;
    cand = pending_q & ~bus.mask & ~clr_vec;
    ovf_d = |(rise & pending_q & ~clr_vec) ? 1'b1 : (bus.clr_ovf ? 1'b0 : ovf_q);
  end
  // a new index may only be loaded when nothing is presented or the current one is accepted
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    if (state_q == IDLE || hs) begin
      state_d = (bus.en && any) ? PRESENT : IDLE;
      idx_d = (bus.en && any) ? enc_idx : idx_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      req_q <= '0;
      pending_q <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      pending_q <= pending_d;
      idx_q <= idx_d;
      ovf_q <= ovf_d;
    end
  assign bus.out_valid = (state_q == PRESENT);
  assign bus.out_idx = idx_q;
  assign bus.pending = pending_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_req_capture_encoder.sv
// tb_req_capture_encoder: directed and random checks against a behavioural event model
module tb_req_capture_encoder;
  import req_enc_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  req_capture_encoder_if bus();
  req_capture_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [N-1:0] m_pend, m_reqp;
  logic m_valid, m_ovf;
  int m_idx;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_pend = '0;
    m_reqp = '0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_idx = 0;
  endtask
  task automatic compare(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(m_valid));
    if (m_valid) chk({tag, "_idx"}, 32'(bus.out_idx), m_idx);
    chk({tag, "_pend"}, 32'(bus.pending), 32'(m_pend));
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(m_ovf));
  endtask
  // one clock: events are fresh rising request levels; the accepted index is consumed,
  // the highest unmasked remaining event is offered whenever the output slot is free
  task automatic step(input string tag);
    logic [N-1:0] np;
    logic nv, no, lost, hs, cl, r;
    int ni, best;
    hs = m_valid && bus.out_ready;
    np = '0;
    lost = 1'b0;
    best = -1;
    for (int i = 0; i < N; i++) begin
      cl = hs && (i == m_idx);
      r = bus.req[i] && !m_reqp[i];
      np[i] = (m_pend[i] && !cl) || r;
      if (r && m_pend[i] && !cl) lost = 1'b1;
    end
    for (int i = N - 1; i >= 0; i--)
      if (best < 0 && m_pend[i] && !bus.mask[i] && !(hs && i == m_idx)) best = i;
    nv = m_valid;
    ni = m_idx;
    if (!m_valid || hs) begin
      nv = bus.en && (best >= 0);
      if (nv) ni = best;
    end
    no = lost ? 1'b1 : (bus.clr_ovf ? 1'b0 : m_ovf);
    @(posedge clk);
    #1;
    m_pend = np;
    m_reqp = bus.req;
    m_valid = nv;
    m_idx = ni;
    m_ovf = no;
    compare(tag);
  endtask
  initial begin
    bus.req = 8'h05;
    bus.mask = '0;
    bus.en = 1'b1;
    bus.out_ready = 1'b1;
    bus.clr_ovf = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_idx", 32'(bus.out_idx), 0);
    chk("rst_pend", 32'(bus.pending), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    // request held high across reset release is captured once
    step("t1a");
    chk("t1_pend05", 32'(bus.pending), 32'h05);
    chk("t1_nov", 32'(bus.out_valid), 0);
    step("t1b");
    chk("t1_idx2", 32'(bus.out_idx), 2);
    step("t1c");
    chk("t1_idx0", 32'(bus.out_idx), 0);
    step("t1d");
    chk("t1_idle", 32'(bus.out_valid), 0);
    chk("t1_empty", 32'(bus.pending), 0);
    // stalled presentation then back-to-back drain
    bus.req = 8'h00;
    step("t2pre");
    bus.req = 8'h83;
    bus.out_ready = 1'b0;
    step("t2a");
    bus.req = 8'h00;
    for (int k = 0; k < 5; k++) begin
      step("t2hold");
      chk("t2_hold7", 32'(bus.out_idx), 7);
      chk("t2_holdv", 32'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    step("t2b");
    chk("t2_idx1", 32'(bus.out_idx), 1);
    step("t2c");
    chk("t2_idx0", 32'(bus.out_idx), 0);
    step("t2d");
    chk("t2_idle", 32'(bus.out_valid), 0);
    // masked bit stays pending until unmasked
    bus.mask = 8'h80;
    bus.req = 8'h81;
    step("t3a");
    bus.req = 8'h00;
    step("t3b");
    chk("t3_idx0", 32'(bus.out_idx), 0);
    step("t3c");
    chk("t3_idle", 32'(bus.out_valid), 0);
    chk("t3_pend80", 32'(bus.pending), 32'h80);
    bus.mask = 8'h00;
    step("t3d");
    chk("t3_idx7", 32'(bus.out_idx), 7);
    step("t3e");
    // overflow on re-rise of a pending bit, clear, and set-over-clear
    bus.out_ready = 1'b0;
    bus.req = 8'h08;
    step("t4a");
    step("t4b");
    bus.req = 8'h00;
    step("t4c");
    bus.req = 8'h08;
    step("t4d");
    chk("t4_ovf", 32'(bus.overflow), 1);
    chk("t4_pend", 32'(bus.pending), 32'h08);
    bus.clr_ovf = 1'b1;
    step("t4e");
    chk("t4_clr", 32'(bus.overflow), 0);
    bus.clr_ovf = 1'b0;
    bus.req = 8'h00;
    step("t4f");
    bus.req = 8'h08;
    bus.clr_ovf = 1'b1;
    step("t4g");
    chk("t4_setwins", 32'(bus.overflow), 1);
    bus.req = 8'h00;
    bus.out_ready = 1'b1;
    step("t4h");
    bus.clr_ovf = 1'b0;
    step("t4i");
    // accept and re-rise in the same cycle is a fresh event
    bus.out_ready = 1'b0;
    bus.req = 8'h10;
    step("t5a");
    bus.req = 8'h00;
    step("t5b");
    chk("t5_idx4", 32'(bus.out_idx), 4);
    bus.out_ready = 1'b1;
    bus.req = 8'h10;
    step("t5c");
    chk("t5_pend4", 32'(bus.pending[4]), 1);
    chk("t5_noovf", 32'(bus.overflow), 0);
    bus.req = 8'h00;
    bus.out_ready = 1'b0;
    step("t5d");
    chk("t5_again4", 32'(bus.out_idx), 4);
    chk("t5_againv", 32'(bus.out_valid), 1);
    // asynchronous reset mid-handshake
    bus.req = 8'hFF;
    step("t6a");
    bus.req = 8'h00;
    step("t6b");
    chk("t6_full", 32'(bus.pending), 32'hFF);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_valid", 32'(bus.out_valid), 0);
    chk("t6_pend", 32'(bus.pending), 0);
    chk("t6_ovf", 32'(bus.overflow), 0);
    #2;
    rst_n = 1'b1;
    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      bus.req = N'($urandom);
      bus.mask = ($urandom % 4 == 0) ? N'($urandom) : '0;
      bus.en = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      bus.clr_ovf = ($urandom % 8) == 0;
      step("rnd");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
